parity_tx: RTL and testbench
============================

// Module: parity_tx
// PURPOSE
//   Transmit end of the serial parity link. Accepts a parallel word, shifts it out LSB-first
//   on data_out with valid_out high, then appends one parity bit (even/odd per mode).
//   Drives the serial parity checker on the receive side: one frame = DATA_W data bits
//   plus 1 parity bit, valid held high continuously, then at least one idle cycle.
// PARAMETERS
//   DATA_W   8   data bits per frame (>=2); frame length on the wire = DATA_W+1 valid cycles
// PORTS
//   clk        in   1        sole clock; all state changes on posedge
//   reset_n    in   1        reset; one clock, reset is asynchronous and active-low
//   tx_data    in   DATA_W   word to send; sampled only on load acceptance
//   tx_load    in   1        load request; accepted when tx_load && tx_ready
//   mode       in   1        0 = even parity, 1 = odd parity; sampled on load acceptance
//   tx_abort   in   1        synchronous abort of the frame in flight
//   tx_ready   out  1        high only in IDLE (decoded from state register)
//   data_out   out  1        serial bit (registered)
//   valid_out  out  1        qualifies data_out (registered)
//   busy       out  1        high in SHIFT/PARITY/GAP (registered)
//   done       out  1        one-cycle pulse, frame completed without abort (registered)
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE, data_out=0, valid_out=0, busy=0, done=0,
//     bit counter=0, shift reg=0, mode latch=0; tx_ready=1 during and after reset.
//   FSM: IDLE -> SHIFT -> PARITY -> GAP -> IDLE.
//   IDLE: on tx_load: latch tx_data into shift reg, latch mode, compute
//     par = ^tx_data ^ mode; go SHIFT. No request: outputs stay 0.
//   SHIFT: one data bit per cycle, LSB first; data_out = shreg[0], valid_out=1, busy=1.
//     First data bit appears on the cycle after the accepting edge (latency 1).
//     Counter runs 0..DATA_W-1, width $clog2(DATA_W+1); after bit DATA_W-1 go PARITY.
//   PARITY: data_out=par, valid_out=1, busy=1 for exactly one cycle; go GAP.
//   GAP: valid_out=0, data_out=0, busy=1, done=1 for exactly one cycle; go IDLE.
//     The guaranteed valid_out-low cycle is what re-arms the receiver's frame counter.
//   Parity rule: total ones over data+parity bit is even (mode 0) or odd (mode 1).
//   tx_load while busy: ignored; no queueing, tx_data/mode changes have no effect.
//   Back-to-back (tx_load held high): frame period DATA_W+3 cycles; valid_out is low
//     for 2 cycles (GAP + IDLE acceptance cycle) between frames.
//   tx_abort in SHIFT or PARITY: next cycle state=IDLE, valid_out=0, busy=0, done stays 0;
//     counter cleared. tx_abort in IDLE or GAP: no effect (GAP still pulses done).
//     If tx_abort and tx_load are both high in IDLE, the load is accepted.
//   reset_n low mid-frame: all outputs to reset values immediately; the frame is lost.
//   valid_out never rises for a partial frame except via abort truncation.
// STRUCTURE
//   Shared package parity_pkg: state encoding (IDLE/SHIFT/PARITY/GAP), MODE_EVEN=1'b0,
//     MODE_ODD=1'b1; the checker imports the same mode constants.
//   No sub-module: FSM, shift reg and bit counter inline, one sequential and one
//     next-state combinational process.
// TESTING
//   1. Load 0xA5, mode=0 -> data_out 1,0,1,0,0,1,0,1 then parity 0; valid_out high 9 cycles; done on cycle 10.
//   2. Load 0xA5, mode=1 -> same data bits, parity 1. Load 0x07, mode=0 -> parity 1.
//   3. tx_load held high with 0xFF/0x00 alternating -> period 11 cycles, 2 low valid cycles between frames, done every 11.
//   4. tx_abort after 3rd data bit -> valid_out low next cycle, busy=0, no done, tx_ready=1; next load sends a full frame.
//   5. tx_load pulsed with 0x3C during SHIFT -> ignored; the in-flight frame bits are unchanged.
//   6. reset_n low at PARITY cycle -> valid_out/data_out/busy/done=0 immediately; tx_ready=1 after release.
//   Scoreboard: loopback into the checker (mode matched) -> parity_ok=1 for every unaborted frame.

Source files
------------

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
//   Definitions shared by both ends of the serial parity link.
//   - tx_state_e : transmitter FSM states
//   - MODE_EVEN / MODE_ODD : parity mode encoding (the receive checker imports
//     the same constants so both ends agree on the meaning of 'mode')
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } tx_state_e;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_tx.sv
// -----------------------------------------------------------------------------
// parity_tx
//   Transmit end of the serial parity link. A parallel word is shifted out
//   LSB-first with valid_out high, followed by one parity bit (even/odd per
//   mode), followed by one idle cycle (valid_out low, done high) that re-arms
//   the receiver's frame counter.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   tx_data    in   [DATA_W-1:0] word to send, sampled on load acceptance
//   tx_load    in   load request, accepted when tx_load && tx_ready
//   mode       in   0 = even parity, 1 = odd parity, sampled on acceptance
//   tx_abort   in   synchronous abort of the frame in SHIFT/PARITY
//   tx_ready   out  high only in IDLE (decoded from the state register)
//   data_out   out  serial bit (registered)
//   valid_out  out  qualifies data_out (registered)
//   busy       out  high in SHIFT/PARITY/GAP (registered)
//   done       out  one-cycle pulse after an unaborted frame (registered)
// -----------------------------------------------------------------------------
module parity_tx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    input  logic              mode,
    input  logic              tx_abort,
    output logic              tx_ready,
    output logic              data_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              mode_q,  mode_d;
    logic              dpar_q,  dpar_d;   // XOR of the latched data word
    logic              dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_EVEN;
            dpar_q  <= 1'b0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dpar_q  <= dpar_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dpar_d  = dpar_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_load) begin
                    shreg_d = tx_data;
                    mode_d  = mode;
                    dpar_d  = ^tx_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tx_abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = ST_PARITY;
                end else begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                state_d = tx_abort ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they line
        // up with state_q; in SHIFT the registered bit equals shreg_q[0].
        dout_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_GAP);
        if (state_d == ST_SHIFT) begin
            dout_d  = shreg_d[0];
            valid_d = 1'b1;
        end else if (state_d == ST_PARITY) begin
            dout_d  = dpar_d ^ mode_d;
            valid_d = 1'b1;
        end
    end

    assign tx_ready  = (state_q == ST_IDLE);
    assign data_out  = dout_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : parity_tx

// File: tb/tb_parity_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_tx
//   Scoreboard bench for parity_tx. Stimulus tasks push the hand-computed
//   expected frame into a queue; a monitor reassembles frames from
//   valid_out/data_out and compares each one as it ends.
// -----------------------------------------------------------------------------
module tb_parity_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic          mode;
    logic          tx_abort;
    logic          tx_ready;
    logic          data_out;
    logic          valid_out;
    logic          busy;
    logic          done;

    parity_tx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .mode      (mode),
        .tx_abort  (tx_abort),
        .tx_ready  (tx_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       par;
        int         len;   // expected valid cycles seen on the wire
        int         gap;   // expected cycles since previous frame start (0 = unchecked)
        bit         lost;  // frame is killed by reset
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [15:0] bits;
        logic [15:0] mask;
        logic [15:0] expb;
        int   nbits;
        int   cyc;
        int   start_cyc;
        int   last_start;
        exp_t e;
        nbits = 0; cyc = 0; start_cyc = 0; last_start = 0; bits = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                if (nbits > 0) begin
                    if (q.size() == 0) check("lost_frame_queue", 0, 1);
                    else begin
                        e = q.pop_front();
                        check("lost_frame_flag", 32'(e.lost), 1);
                    end
                end
                nbits = 0;
                bits  = '0;
            end else if (valid_out) begin
                if (nbits == 0) start_cyc = cyc;
                if (nbits < 16) bits[nbits] = data_out;
                nbits++;
            end else if (nbits > 0) begin
                if (q.size() == 0) check("frame_unexpected", 0, 1);
                else begin
                    e = q.pop_front();
                    check("frame_not_lost", 32'(e.lost), 0);
                    check("frame_len", 32'(nbits), 32'(e.len));
                    mask = (16'h1 << e.len) - 16'h1;
                    expb = {7'b0, e.par, e.data};
                    check("frame_bits", 32'(bits & mask), 32'(expb & mask));
                    if (e.len == DW + 1) begin
                        check("parity_rule", 32'(^bits[8:0]), 32'(e.mode));
                        check("done_pulse", 32'(done), 1);
                        check("busy_in_gap", 32'(busy), 1);
                        check("ready_in_gap", 32'(tx_ready), 0);
                    end else begin
                        check("abort_no_done", 32'(done), 0);
                        check("abort_busy", 32'(busy), 0);
                        check("abort_ready", 32'(tx_ready), 1);
                    end
                    if (e.gap != 0) check("frame_period", 32'(start_cyc - last_start), 32'(e.gap));
                end
                last_start = start_cyc;
                nbits = 0;
                bits  = '0;
            end else if (done) begin
                check("spurious_done", 32'(done), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int k;
        for (k = 0; k < 40; k++) begin
            if (tx_ready) break;
            @(posedge clk); #1;
        end
        if (k == 40) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic m, input logic p, input int abort_after);
        exp_t e;
        wait_ready();
        e = '{data: d, mode: m, par: p, len: (abort_after > 0) ? abort_after : DW + 1, gap: 0, lost: 1'b0};
        q.push_back(e);
        tx_data = d; mode = m; tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0; tx_data = ~d; mode = ~m;
        if (abort_after > 0) begin
            repeat (abort_after - 1) @(posedge clk);
            #1 tx_abort = 1'b1;
            @(posedge clk); #1;
            tx_abort = 1'b0;
        end
        wait_ready();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [7:0] b2b_data [4];

    initial begin : stim
        exp_t e;
        b2b_data[0] = 8'hFF; b2b_data[1] = 8'h00; b2b_data[2] = 8'hFF; b2b_data[3] = 8'h00;
        reset_n = 1'b0; tx_data = '0; tx_load = 1'b0; mode = 1'b0; tx_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // 1/2: basic frames
        send(8'hA5, 1'b0, 1'b0, 0);
        send(8'hA5, 1'b1, 1'b1, 0);
        send(8'h07, 1'b0, 1'b1, 0);

        // 3: tx_load held high, alternating 0xFF / 0x00
        wait_ready();
        tx_load = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            e = '{data: b2b_data[i], mode: 1'b0, par: 1'b0, len: DW + 1, gap: (i == 0) ? 0 : DW + 3, lost: 1'b0};
            q.push_back(e);
            tx_data = b2b_data[i];
            @(posedge clk); #1;
            if (i == 3) tx_load = 1'b0;
        end
        wait_ready();

        // 4: abort after 3rd data bit (0xC3 -> 1,1,0), then a full frame
        send(8'hC3, 1'b0, 1'b0, 3);
        send(8'h5A, 1'b1, 1'b1, 0);

        // 5: load pulse with 0x3C during SHIFT is ignored
        wait_ready();
        e = '{data: 8'h96, mode: 1'b0, par: 1'b0, len: DW + 1, gap: 0, lost: 1'b0};
        q.push_back(e);
        tx_data = 8'h96; mode = 1'b0; tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_not_ready", 32'(tx_ready), 0);
        tx_data = 8'h3C; mode = 1'b1; tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
        wait_ready();

        // 6: reset during PARITY of 0x83 (even parity bit = 1)
        e = '{data: 8'h83, mode: 1'b0, par: 1'b1, len: 0, gap: 0, lost: 1'b1};
        q.push_back(e);
        tx_data = 8'h83; mode = 1'b0; tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("parity_cycle_valid", 32'(valid_out), 1);
        check("parity_cycle_bit", 32'(data_out), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_out), 0);
        check("midrst_dout", 32'(data_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_ready", 32'(tx_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", 32'(tx_ready), 1);
        check("postrst_valid", 32'(valid_out), 0);
        send(8'h01, 1'b1, 1'b0, 0);

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_parity_tx
